// File: rtl/scr_pkg.sv
// Shared constants, FIFO entry type and LFSR step for the multi-channel scrambler.
package scr_pkg;

  localparam int unsigned CH_MAXW = 3;
  localparam int unsigned XW      = 32;

  localparam logic [3:0] OFF_SEED = 4'h0;
  localparam logic [3:0] OFF_POLY = 4'h4;
  localparam logic [3:0] OFF_CTRL = 4'h8;

  localparam logic [XW-1:0] RST_SEED = 32'h0000_0001;
  localparam logic [XW-1:0] RST_POLY = 32'h8020_0003;

  typedef struct packed {
    logic [CH_MAXW-1:0] ch;
    logic [XW-1:0]      data;
  } scr_entry_t;

  // One Galois LFSR step
  function automatic logic [XW-1:0] galois_next(input logic [XW-1:0] s, input logic [XW-1:0] poly);
    return (s >> 1) ^ (s[0] ? poly : 32'h0);
  endfunction

endpackage

// File: rtl/scrambler_mc_if.sv
// Register bus, input stream and output stream of scrambler_mc.
interface scrambler_mc_if #(
  parameter int unsigned DW  = 8,
  parameter int unsigned NCH = 4
);
  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic          write;
  logic [11:0]   addr;
  logic [31:0]   lfsrdin;
  logic          pushin;
  logic [CW-1:0] chin;
  logic [DW-1:0] datain;
  logic [31:0]   entrophy;
  logic          stallout;
  logic          pushout;
  logic [CW-1:0] chout;
  logic [31:0]   dataout;
  logic          stopin;
  logic [15:0]   dropcnt;

  modport master (
    output write, addr, lfsrdin, pushin, chin, datain, entrophy, stopin,
    input  stallout, pushout, chout, dataout, dropcnt
  );

  modport slave (
    input  write, addr, lfsrdin, pushin, chin, datain, entrophy, stopin,
    output stallout, pushout, chout, dataout, dropcnt
  );
endinterface

// File: rtl/scr_fifo.sv
// Output FIFO with a registered head view: head/head_vld are flops that
// always show the oldest entry and stay stable while stop is high.
module scr_fifo
  import scr_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CNTW  = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  scr_entry_t      wr_data,
  input  logic            stop,
  output logic            head_vld,
  output scr_entry_t      head,
  output logic [CNTW-1:0] count
);

  scr_entry_t      mem_q [DEPTH];
  scr_entry_t      mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            head_vld_q, head_vld_d;
  scr_entry_t      head_q, head_d;
  logic            rd_c;

  // Pointer/count update and next head selection (bypasses a same-cycle write)
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    head_d     = head_q;
    rd_c       = head_vld_q & ~stop;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d    = count_q + CNTW'(wr_en) - CNTW'(rd_c);
    head_vld_d = (count_d != '0);
    if (head_vld_d) begin
      head_d = mem_d[rd_ptr_d];
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_vld_q <= 1'b0;
      head_q     <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_vld_q <= head_vld_d;
      head_q     <= head_d;
    end
  end

  assign head_vld = head_vld_q;
  assign head     = head_q;
  assign count    = count_q;

endmodule

// File: rtl/scrambler_mc.sv
// Multi-channel LFSR scrambler: per-channel Galois LFSRs programmed over a
// small register bus, one result stage, then an in-order output FIFO.
// Optional build macro: SCRAMBLER_DROPCNT_EN enables the dropped-input counter.
module scrambler_mc
  import scr_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned DEPTH = 8
) (
  input logic           clk,
  input logic           rst,
  scrambler_mc_if.slave bus
);

  localparam int unsigned CW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH) + 1;
  localparam int unsigned NW   = CNTW + 1;

  logic [31:0]     lfsr_q [NCH];
  logic [31:0]     lfsr_d [NCH];
  logic [31:0]     poly_q [NCH];
  logic [31:0]     poly_d [NCH];
  logic [NCH-1:0]  en_q, en_d;
  logic            stg_vld_q, stg_vld_d;
  scr_entry_t      stg_q, stg_d;
  logic            stall_q, stall_d;

  logic [31:0]     cur_lfsr_c, cur_poly_c, next_c;
  logic            chan_en_c, acc_c, reg_hit_c, pop_c;
  logic [NW-1:0]   occ_nxt_c;

  logic            head_vld;
  scr_entry_t      head;
  logic [CNTW-1:0] fifo_cnt;

  // Select the addressed channel's state and decide acceptance
  always_comb begin
    cur_lfsr_c = '0;
    cur_poly_c = '0;
    chan_en_c  = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (bus.chin == CW'(i)) begin
        cur_lfsr_c = lfsr_q[i];
        cur_poly_c = poly_q[i];
        chan_en_c  = en_q[i];
      end
    end
    acc_c  = bus.pushin & ~stall_q & chan_en_c;
    next_c = galois_next(cur_lfsr_c, cur_poly_c);
  end

  // Per-channel LFSR/poly/enable update; a register write overrides a same-cycle advance
  always_comb begin
    lfsr_d    = lfsr_q;
    poly_d    = poly_q;
    en_d      = en_q;
    reg_hit_c = bus.write && (bus.addr[11:8] == 4'h0);
    for (int unsigned i = 0; i < NCH; i++) begin
      if (acc_c && (bus.chin == CW'(i))) begin
        lfsr_d[i] = next_c;
      end
      if (reg_hit_c && (bus.addr[7:4] == 4'(i))) begin
        case (bus.addr[3:0])
          OFF_SEED: lfsr_d[i] = (bus.lfsrdin == 32'h0) ? RST_SEED : bus.lfsrdin;
          OFF_POLY: poly_d[i] = bus.lfsrdin;
          OFF_CTRL: en_d[i]   = bus.lfsrdin[0];
          default:  ;
        endcase
      end
    end
  end

  // Result stage and registered stall from next-cycle occupancy
  always_comb begin
    stg_vld_d    = acc_c;
    stg_d.ch     = CH_MAXW'(bus.chin);
    stg_d.data   = next_c ^ bus.entrophy ^ 32'(bus.datain);
    pop_c        = head_vld & ~bus.stopin;
    occ_nxt_c    = NW'(fifo_cnt) + NW'(stg_vld_q) - NW'(pop_c) + NW'(acc_c);
    stall_d      = (occ_nxt_c >= NW'(DEPTH - 1));
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        lfsr_q[i] <= RST_SEED;
        poly_q[i] <= RST_POLY;
      end
      en_q      <= '0;
      stg_vld_q <= 1'b0;
      stg_q     <= '0;
      stall_q   <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_d;
      poly_q    <= poly_d;
      en_q      <= en_d;
      stg_vld_q <= stg_vld_d;
      stg_q     <= stg_d;
      stall_q   <= stall_d;
    end
  end

  scr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (stg_vld_q),
    .wr_data  (stg_q),
    .stop     (bus.stopin),
    .head_vld (head_vld),
    .head     (head),
    .count    (fifo_cnt)
  );

`ifdef SCRAMBLER_DROPCNT_EN
  logic [15:0] dropcnt_q, dropcnt_d;

  // Saturating count of offered-but-not-accepted inputs
  always_comb begin
    dropcnt_d = dropcnt_q;
    if (bus.pushin && !acc_c && (dropcnt_q != 16'hFFFF)) begin
      dropcnt_d = dropcnt_q + 16'd1;
    end
  end

  // Drop counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      dropcnt_q <= '0;
    end else begin
      dropcnt_q <= dropcnt_d;
    end
  end

  assign bus.dropcnt = dropcnt_q;
`else
  assign bus.dropcnt = 16'h0;
`endif

  assign bus.stallout = stall_q;
  assign bus.pushout  = head_vld;
  assign bus.chout    = CW'(head.ch);
  assign bus.dataout  = head.data;

endmodule

// File: doc/scrambler_mc.md
SCRAMBLER_MC -- requirements
Module: scrambler_mc

Interface
REQ-001 SHALL have parameter DW, default 8, input data width (8..32).
REQ-002 SHALL have parameter NCH, default 4, channel count (1..8); CW = max(1, clog2(NCH)).
REQ-003 SHALL have parameter DEPTH, default 8, output FIFO depth (power of 2, 4..16).
REQ-004 SHALL have ports: clk input 1 clock; rst input 1 reset, synchronous, active-low.
REQ-005 SHALL have ports: write input 1 register write strobe; addr input 12 register address; lfsrdin input 32 register write data.
REQ-006 SHALL have ports: pushin input 1 data valid; chin input CW channel; datain input DW data; entrophy input 32 entropy word; stallout output 1 input not accepted.
REQ-007 SHALL have ports: pushout output 1 result valid; chout output CW result channel; dataout output 32 result; stopin input 1 downstream stall; dropcnt output 16 dropped-input count.

Function
REQ-008 Address map: addr[11:8] SHALL be 0 or the write is ignored; addr[7:4] is the channel; addr[3:0] = 0 seed, 4 poly, 8 ctrl (bit0 enable); other offsets and channels >= NCH SHALL be ignored.
REQ-009 Seed write SHALL load the channel LFSR state; a seed of 0 SHALL load 32'h00000001.
REQ-010 Per-channel LFSR SHALL be 32-bit Galois: next = (s >> 1) ^ (s[0] ? poly : 0), advanced exactly once per accepted input.
REQ-011 Accepted input: pushin=1 and stallout=0 and channel enabled and chin < NCH.
REQ-012 Result SHALL be next ^ entrophy ^ zero-extended datain; chout = chin.
REQ-013 Input not accepted while pushin=1 SHALL be dropped with no LFSR advance, and dropcnt SHALL increment, saturating at 16'hFFFF.
REQ-014 Write and accepted push to the same channel in the same cycle: push SHALL use the pre-write state; the written value SHALL win and the push's advance is discarded.
REQ-015 Latency: the result SHALL be registered into a stage one cycle after acceptance, then written into the FIFO; minimum pushin-to-pushout latency SHALL be 2 clocks.
REQ-016 pushout SHALL be 1 whenever the FIFO is non-empty; pushout, chout and dataout SHALL be registered and held stable while stopin=1.
REQ-017 A head entry SHALL retire in the cycle pushout=1 and stopin=0; results SHALL leave in acceptance order across all channels.
REQ-018 stallout SHALL be registered and SHALL be 1 when FIFO occupancy plus staged entry >= DEPTH-1, so the FIFO never overflows.
REQ-019 Simultaneous FIFO write and retire when full-minus-one SHALL leave occupancy unchanged.

Reset
REQ-020 On rst=0 at a clock edge:
- all LFSR states SHALL be 32'h00000001
- all polys SHALL be 32'h80200003
- all enables SHALL be 0
- the FIFO and stage SHALL be emptied
- pushout, stallout, chout, dataout and dropcnt SHALL be 0
REQ-021 Reset asserted mid-stream SHALL discard all in-flight results; no pushout for 2 clocks after release.

Configuration
REQ-022 With SCRAMBLER_DROPCNT_EN defined, dropcnt SHALL count per REQ-013.
REQ-023 Without SCRAMBLER_DROPCNT_EN, dropcnt SHALL be constant 0, no counter flops SHALL exist, and drop behaviour is otherwise unchanged.

Structure
REQ-024 Package scr_pkg SHALL hold: register offset constants, reset poly/seed constants, and the FIFO entry typedef (channel + 32-bit data).
REQ-025 The output FIFO SHALL be sub-module scr_fifo (parameter DEPTH, count output).

Verification
REQ-026 Default poly; enable ch0; seed ch0 = 1; push ch0 datain=A5, entropy 0 -> dataout 802000A6, chout 0, 2 clocks later.
REQ-027 Immediately push ch0 datain=00, entropy 0 -> dataout C0300002; then write seed 0 and push 00 -> dataout 80200003.
REQ-028 Push to disabled ch1 three times -> no pushout; dropcnt=3 (0 without macro).
REQ-029 Hold stopin=1 and stream ch0 pushes -> stallout rises after DEPTH-1 entries, no loss; release stopin -> all values in order.
REQ-030 Same-cycle seed write 1 and push on ch0 -> result uses old state; the next push yields the 80200003-based value.
REQ-031 Assert rst with 3 results queued -> pushout 0, dropcnt 0, no stale output after release.
